// File: rtl/glitch_pkg.sv
// Shared state encoding, trigger mode constants and sizing helper for the glitch sequencer.
package glitch_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_TRST  = 3'd1;
    localparam logic [2:0] ST_ARMED = 3'd2;
    localparam logic [2:0] ST_DELAY = 3'd3;
    localparam logic [2:0] ST_PULSE = 3'd4;
    localparam logic [2:0] ST_SPACE = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_TRST  = ST_TRST,
        S_ARMED = ST_ARMED,
        S_DELAY = ST_DELAY,
        S_PULSE = ST_PULSE,
        S_SPACE = ST_SPACE
    } state_t;

    localparam logic [1:0] TRIG_RISE  = 2'b00;
    localparam logic [1:0] TRIG_FALL  = 2'b01;
    localparam logic [1:0] TRIG_LEVEL = 2'b10;
    localparam logic [1:0] TRIG_IMM   = 2'b11;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/trigger_sync.sv
// Trigger synchroniser: metastability flop chain plus one history flop for edge detection.
module trigger_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic trigger_i,
    output logic trig_s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], trigger_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign trig_s = sync_q[SYNC_STAGES-1];
    assign rise   = trig_s & ~prev_q;
    assign fall   = ~trig_s & prev_q;

endmodule

// File: rtl/glitch_sequencer.sv
// Glitch pulse sequencer: optional target reset, qualified trigger wait with timeout,
// then a delayed train of glitch pulses. All outputs come straight from flops.
module glitch_sequencer
    import glitch_pkg::*;
#(
    parameter int DELAY_W     = 16,
    parameter int WIDTH_W     = 8,
    parameter int COUNT_W     = 8,
    parameter int SPACING_W   = 16,
    parameter int RESET_W     = 16,
    parameter int TIMEOUT_W   = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 arm_i,
    input  logic                 abort_i,
    input  logic [1:0]           trig_mode_i,
    input  logic                 trigger_i,
    input  logic [RESET_W-1:0]   reset_len_i,
    input  logic [DELAY_W-1:0]   delay_i,
    input  logic [WIDTH_W-1:0]   width_i,
    input  logic [COUNT_W-1:0]   num_pulses_i,
    input  logic [SPACING_W-1:0] spacing_i,
    input  logic [TIMEOUT_W-1:0] timeout_i,
    output logic                 pulse_o,
    output logic                 target_reset_o,
    output logic                 busy_o,
    output logic                 armed_o,
    output logic                 done_o,
    output logic                 timeout_o,
    output logic [COUNT_W-1:0]   pulse_count_o
);

    localparam int CNT_W = max4(DELAY_W, WIDTH_W, SPACING_W, RESET_W);

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [TIMEOUT_W-1:0] tmo_cnt;

    // reset_len is consumed in the arm cycle itself, so it needs no shadow copy.
    logic [1:0]           trig_mode_q;
    logic [DELAY_W-1:0]   delay_q;
    logic [WIDTH_W-1:0]   width_q;
    logic [COUNT_W-1:0]   num_pulses_q;
    logic [SPACING_W-1:0] spacing_q;
    logic [TIMEOUT_W-1:0] timeout_q;

    logic                 trig_s;
    logic                 trig_rise;
    logic                 trig_fall;
    logic                 trig_event;
    logic [WIDTH_W-1:0]   width_eff;
    logic [SPACING_W-1:0] spacing_eff;
    logic [COUNT_W-1:0]   num_eff;
    logic                 last_pulse;
    logic                 tmo_expired;

    trigger_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_trigger_sync (
        .clk       (clk),
        .rst       (rst),
        .trigger_i (trigger_i),
        .trig_s    (trig_s),
        .rise      (trig_rise),
        .fall      (trig_fall)
    );

    assign width_eff   = (width_q == '0)      ? WIDTH_W'(1)   : width_q;
    assign spacing_eff = (spacing_q == '0)    ? SPACING_W'(1) : spacing_q;
    assign num_eff     = (num_pulses_q == '0) ? COUNT_W'(1)   : num_pulses_q;
    assign last_pulse  = (pulse_count_o + COUNT_W'(1)) == num_eff;
    assign tmo_expired = (timeout_q != '0) && (tmo_cnt == timeout_q - TIMEOUT_W'(1));

    always_comb begin
        trig_event = 1'b0;
        case (trig_mode_q)
            TRIG_RISE:  trig_event = trig_rise;
            TRIG_FALL:  trig_event = trig_fall;
            TRIG_LEVEL: trig_event = trig_s;
            default:    trig_event = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            tmo_cnt        <= '0;
            trig_mode_q    <= '0;
            delay_q        <= '0;
            width_q        <= '0;
            num_pulses_q   <= '0;
            spacing_q      <= '0;
            timeout_q      <= '0;
            pulse_o        <= 1'b0;
            target_reset_o <= 1'b0;
            busy_o         <= 1'b0;
            armed_o        <= 1'b0;
            done_o         <= 1'b0;
            timeout_o      <= 1'b0;
            pulse_count_o  <= '0;
        end else begin
            done_o    <= 1'b0;
            timeout_o <= 1'b0;
            if (abort_i) begin
                state          <= S_IDLE;
                pulse_o        <= 1'b0;
                target_reset_o <= 1'b0;
                busy_o         <= 1'b0;
                armed_o        <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (arm_i) begin
                            trig_mode_q   <= trig_mode_i;
                            delay_q       <= delay_i;
                            width_q       <= width_i;
                            num_pulses_q  <= num_pulses_i;
                            spacing_q     <= spacing_i;
                            timeout_q     <= timeout_i;
                            pulse_count_o <= '0;
                            busy_o        <= 1'b1;
                            if (reset_len_i != '0) begin
                                state          <= S_TRST;
                                target_reset_o <= 1'b1;
                                cnt            <= CNT_W'(reset_len_i) - CNT_W'(1);
                            end else begin
                                state   <= S_ARMED;
                                armed_o <= 1'b1;
                                tmo_cnt <= '0;
                            end
                        end
                    end
                    S_TRST: begin
                        if (cnt == '0) begin
                            state          <= S_ARMED;
                            target_reset_o <= 1'b0;
                            armed_o        <= 1'b1;
                            tmo_cnt        <= '0;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    S_ARMED: begin
                        // An event in the expiry cycle still wins over the timeout.
                        if (trig_event) begin
                            armed_o <= 1'b0;
                            if (delay_q == '0) begin
                                state   <= S_PULSE;
                                pulse_o <= 1'b1;
                                cnt     <= CNT_W'(width_eff) - CNT_W'(1);
                            end else begin
                                state <= S_DELAY;
                                cnt   <= CNT_W'(delay_q) - CNT_W'(1);
                            end
                        end else if (tmo_expired) begin
                            state     <= S_IDLE;
                            armed_o   <= 1'b0;
                            busy_o    <= 1'b0;
                            timeout_o <= 1'b1;
                        end else if (tmo_cnt != '1) begin
                            tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
                        end
                    end
                    S_DELAY: begin
                        if (cnt == '0) begin
                            state   <= S_PULSE;
                            pulse_o <= 1'b1;
                            cnt     <= CNT_W'(width_eff) - CNT_W'(1);
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    S_PULSE: begin
                        if (cnt == '0) begin
                            pulse_o       <= 1'b0;
                            pulse_count_o <= pulse_count_o + COUNT_W'(1);
                            if (last_pulse) begin
                                state  <= S_IDLE;
                                busy_o <= 1'b0;
                                done_o <= 1'b1;
                            end else begin
                                state <= S_SPACE;
                                cnt   <= CNT_W'(spacing_eff) - CNT_W'(1);
                            end
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    S_SPACE: begin
                        if (cnt == '0) begin
                            state   <= S_PULSE;
                            pulse_o <= 1'b1;
                            cnt     <= CNT_W'(width_eff) - CNT_W'(1);
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    default: begin
                        state          <= S_IDLE;
                        pulse_o        <= 1'b0;
                        target_reset_o <= 1'b0;
                        busy_o         <= 1'b0;
                        armed_o        <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
